ram_4k_arbiter: RTL
===================

Name: ram_4k_arbiter

Overview:
Shares a single ram_4k instance between two requesters, A (CPU data port) and B (DMA/screen refresh). Arbitration is round-robin per cycle, with an optional lock that lets the current owner hold the RAM for atomic multi-cycle sequences such as read-modify-write. Drives the RAM address/data/load pins and returns registered read data to each requester. Sits between the requesters and ram_4k, which shares the same clock.

Parameters:
ADDR_W, 12, RAM address width (4K words)
DATA_W, 16, data word width
LOCK_MAX, 15, max consecutive locked grants before forced release (4-bit counter)

Ports:
clock  input  1  system clock; RAM and arbiter both update on the rising edge
reset  input  1  synchronous, active-high reset
req_a  input  1  A requests an access this cycle
we_a  input  1  A access is a write (valid with req_a)
lock_a  input  1  A wants to keep ownership after this access
addr_a  input  ADDR_W  A address
wdata_a  input  DATA_W  A write data
ack_a  output  1  A's access is performed this cycle (combinational)
rdata_a  output  DATA_W  A read data, registered
rvalid_a  output  1  one-cycle pulse: rdata_a holds the result of A's previous-cycle read
req_b, we_b, lock_b, addr_b, wdata_b, ack_b, rdata_b, rvalid_b  same as A, for requester B
ram_addr  output  ADDR_W  to ram_4k addr
ram_in  output  DATA_W  to ram_4k in
ram_load  output  1  to ram_4k load
ram_out  input  DATA_W  from ram_4k out (combinational read of ram_addr)

Behaviour:
- Reset (while reset=1 at a rising edge): state=IDLE; priority pointer favours A; lock counter=0; rdata_a/b=0; rvalid_a/b=0. While reset is asserted, ack_a/b=0 and ram_load=0, so no write occurs on the reset edge.
- State machine: IDLE, OWN_A, OWN_B. Grant is decided combinationally each cycle.
- IDLE: grant goes to the single requester if only one asserts req. If both request, grant goes to the priority-pointer side.
- OWN_A: A is granted if req_a=1, and B is never granted. OWN_B is symmetric.
- Datapath for the granted side x: ack_x=1, ram_addr=addr_x, ram_in=wdata_x, ram_load=we_x.
- With no grant: ram_load=0, ram_addr holds its last granted address, and ram_in=0.
- A write commits at the rising edge of the ack cycle.
- A granted read latches ram_out into rdata_x at the ack edge. rvalid_x=1 for exactly the following cycle; otherwise rvalid_x=0. rdata_x holds its value until the next read by x.
- Read latency: 1 cycle from ack to rvalid.
- Priority pointer: after any unlocked grant it points at the other requester. It is unchanged in cycles with no grant.
- State transitions at each edge:
  - IDLE→OWN_x when x is granted with lock_x=1.
  - OWN_x→IDLE when x is granted with lock_x=0.
  - OWN_x→IDLE when x has req_x=0 for a cycle (idle owner releases).
  - OWN_x→IDLE when the lock counter reaches LOCK_MAX; the pointer then moves to the other side.
- Lock counter: increments on each locked grant, clears on entry to IDLE, and saturates at LOCK_MAX.
- Ungranted requesters stall: they hold req and inputs stable until ack. The arbiter never queues.
- Reset mid-lock returns to IDLE immediately; an in-flight rvalid is squashed to 0.

Test Plan:
- Single requester: A writes 0x1234 to addr 0x0A5 (ack_a=1 same cycle), then reads 0x0A5 → rvalid_a=1 next cycle, rdata_a=0x1234; rvalid_b stays 0.
- Contention after reset: req_a=req_b=1 writes to 0x010/0x020 → cycle 1 ack_a only, cycle 2 ack_b only. Reads back give the values written.
- Round-robin fairness: A and B both request continuously for 8 cycles → acks alternate A,B,A,B…, with 4 grants each.
- Lock: A does a locked read of 0x100 then an unlocked write to 0x100 while B requests throughout → B is not acked until the cycle after A's unlocked write. B's later read of 0x100 returns A's new value.
- Lock timeout: A holds req_a=lock_a=1 indefinitely while B requests → A gets exactly LOCK_MAX (15) consecutive acks, then B is acked.
- Reset mid-lock: assert reset while in OWN_B with a read just acked → next cycle rvalid_b=0, ram_load=0, and after reset A wins a simultaneous request.

Source files
------------

// File: rtl/ram_4k_arbiter.sv
// Two-requester arbiter in front of a single ram_4k: per-cycle round-robin
// grant, with an optional bounded lock for atomic multi-cycle sequences.

// Read-return slice for one requester: captures ram_out on a granted read.
module ram_4k_arbiter_rd #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_rd,
  input  logic [DATA_W-1:0] i_ram_out,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid
);
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= i_rd;
      if (i_rd) r_rdata <= i_ram_out;
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
endmodule

module ram_4k_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_a,
  input  logic              we_a,
  input  logic              lock_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rvalid_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic              lock_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_b,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);
  localparam int NUM_LANES = 2;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_prio, w_prio_nxt;   // 0 favours A, 1 favours B
  logic [CNT_W-1:0]  r_lock_cnt, w_lock_cnt_nxt, w_cnt_inc;
  logic [ADDR_W-1:0] r_last_addr;

  logic [NUM_LANES-1:0]             w_req, w_we, w_lock, w_gnt, w_rvalid;
  logic [NUM_LANES-1:0][ADDR_W-1:0] w_addr;
  logic [NUM_LANES-1:0][DATA_W-1:0] w_wdata, w_rdata;
  logic                             w_any, w_gsel, w_glock;

  assign w_req   = {req_b, req_a};
  assign w_we    = {we_b, we_a};
  assign w_lock  = {lock_b, lock_a};
  assign w_addr  = {addr_b, addr_a};
  assign w_wdata = {wdata_b, wdata_a};

  always_comb begin
    w_gnt = '0;
    if (!reset) begin
      case (r_state)
        IDLE:    w_gnt = (req_a && req_b) ? (r_prio ? 2'b10 : 2'b01) : w_req;
        OWN_A:   w_gnt = {1'b0, req_a};
        OWN_B:   w_gnt = {req_b, 1'b0};
        default: w_gnt = '0;
      endcase
    end
  end

  assign w_any     = |w_gnt;
  assign w_gsel    = w_gnt[1];
  assign w_glock   = w_lock[w_gsel];
  assign w_cnt_inc = (r_lock_cnt == CNT_W'(LOCK_MAX)) ? r_lock_cnt
                                                      : r_lock_cnt + CNT_W'(1);

  // A locked grant that brings the counter to LOCK_MAX is the last one:
  // ownership drops and the other side gets priority.
  always_comb begin
    w_state_nxt    = r_state;
    w_prio_nxt     = r_prio;
    w_lock_cnt_nxt = r_lock_cnt;
    if (w_any) begin
      if (w_glock && (w_cnt_inc != CNT_W'(LOCK_MAX))) begin
        w_state_nxt    = w_gsel ? OWN_B : OWN_A;
        w_lock_cnt_nxt = w_cnt_inc;
      end else begin
        w_state_nxt    = IDLE;
        w_lock_cnt_nxt = '0;
        w_prio_nxt     = ~w_gsel;
      end
    end else if (r_state != IDLE) begin
      w_state_nxt    = IDLE;
      w_lock_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_prio      <= 1'b0;
      r_lock_cnt  <= '0;
      r_last_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prio     <= w_prio_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      if (w_any) r_last_addr <= w_addr[w_gsel];
    end
  end

  assign ram_load = w_any & w_we[w_gsel];
  assign ram_addr = w_any ? w_addr[w_gsel] : r_last_addr;
  assign ram_in   = w_any ? w_wdata[w_gsel] : '0;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_rd
    ram_4k_arbiter_rd #(.DATA_W(DATA_W)) u_rd (
      .clock     (clock),
      .reset     (reset),
      .i_rd      (w_gnt[i] & ~w_we[i]),
      .i_ram_out (ram_out),
      .o_rdata   (w_rdata[i]),
      .o_rvalid  (w_rvalid[i])
    );
  end

  assign ack_a    = w_gnt[0];
  assign ack_b    = w_gnt[1];
  assign rdata_a  = w_rdata[0];
  assign rdata_b  = w_rdata[1];
  assign rvalid_a = w_rvalid[0];
  assign rvalid_b = w_rvalid[1];
endmodule
